// File: rtl/alu_dst_writeback_pkg.sv
// Destination/source code constants shared by the writeback stage and the ALU source muxes.
// Register bank slot indices are also kept here so both sides agree.
package alu_dst_writeback_pkg;

    localparam int DATA_W = 16;

    typedef logic [7:0] alu_code_t;

    // NONE and ZERO share an encoding: "no destination" and "constant zero source".
    localparam alu_code_t CODE_NONE = 8'b0001_0000;
    localparam alu_code_t CODE_ZERO = 8'b0001_0000;
    localparam alu_code_t CODE_RX   = 8'b0000_0101;
    localparam alu_code_t CODE_IN   = 8'b0000_1000;
    localparam alu_code_t CODE_SP   = 8'b0000_1001;
    localparam alu_code_t CODE_T    = 8'b0000_1010;
    localparam alu_code_t CODE_PC   = 8'b0001_0011;
    // Immediate is a source-only code; as a destination it is illegal.
    localparam alu_code_t CODE_IMM  = 8'b0001_0001;

    localparam int NUM_SREGS = 3;
    localparam int SREG_SP   = 0;
    localparam int SREG_T    = 1;
    localparam int SREG_IH   = 2;

endpackage

// File: rtl/alu_dst_writeback_if.sv
// Writeback bus: result/destination in from EX, strobes and special registers out.
interface alu_dst_writeback_if;
    import alu_dst_writeback_pkg::*;

    logic                wb_valid;
    logic                stall;
    logic                flush;
    alu_code_t           ALU_Dst;
    logic [2:0]          rd_addr;
    logic [DATA_W-1:0]   result;

    logic                reg_we;
    logic [2:0]          reg_waddr;
    logic [DATA_W-1:0]   reg_wdata;
    logic                pc_load;
    logic [DATA_W-1:0]   pc_target;
    logic [DATA_W-1:0]   data_SP;
    logic [DATA_W-1:0]   data_T;
    logic [DATA_W-1:0]   data_IN;
    logic                dst_err;
    logic                dst_err_sticky;

    modport master (
        output wb_valid, stall, flush, ALU_Dst, rd_addr, result,
        input  reg_we, reg_waddr, reg_wdata, pc_load, pc_target,
        input  data_SP, data_T, data_IN, dst_err, dst_err_sticky
    );

    modport slave (
        input  wb_valid, stall, flush, ALU_Dst, rd_addr, result,
        output reg_we, reg_waddr, reg_wdata, pc_load, pc_target,
        output data_SP, data_T, data_IN, dst_err, dst_err_sticky
    );

endinterface

// File: rtl/alu_dst_writeback_special_reg_bank.sv
// SP/T/IH storage: one shared write data bus, per-register enables, per-register reset values.
module special_reg_bank #(
    parameter int NUM_REGS = 3,
    parameter int W        = 16,
    parameter logic [NUM_REGS-1:0][W-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REGS-1:0]          we,
    input  logic [W-1:0]                 wdata,
    output logic [NUM_REGS-1:0][W-1:0]   q
);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst)
                q[i] <= RST_VAL[i];
            else if (we[i])
                q[i] <= wdata;
        end
    end

endmodule

// File: rtl/alu_dst_writeback.sv
// EX/WB destination stage: decodes ALU_Dst, updates SP/T/IH and issues registered
// one-cycle strobes for register-file writes, PC loads and illegal destinations.
module alu_dst_writeback
    import alu_dst_writeback_pkg::*;
#(
    parameter logic [15:0] SP_INIT = 16'hBF00,
    parameter int          WIDTH   = DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    alu_dst_writeback_if.slave bus
);

    logic accept;
    logic sel_rx, sel_pc, sel_sp, sel_t, sel_in, illegal;

    logic             reg_we_q, pc_load_q, dst_err_q, sticky_q;
    logic [2:0]       reg_waddr_q;
    logic [WIDTH-1:0] reg_wdata_q, pc_target_q;

    logic [NUM_SREGS-1:0]            sreg_we;
    logic [NUM_SREGS-1:0][WIDTH-1:0] sreg_q;

    // Flush dominates stall and valid: a squashed slot never reaches state.
    assign accept = bus.wb_valid & ~bus.stall & ~bus.flush;

    always_comb begin
        sel_rx  = 1'b0;
        sel_pc  = 1'b0;
        sel_sp  = 1'b0;
        sel_t   = 1'b0;
        sel_in  = 1'b0;
        illegal = 1'b0;
        case (bus.ALU_Dst)
            CODE_NONE: ;
            CODE_RX:   sel_rx = 1'b1;
            CODE_PC:   sel_pc = 1'b1;
            CODE_SP:   sel_sp = 1'b1;
            CODE_T:    sel_t  = 1'b1;
            CODE_IN:   sel_in = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

    always_comb begin
        sreg_we          = '0;
        sreg_we[SREG_SP] = accept & sel_sp;
        sreg_we[SREG_T]  = accept & sel_t;
        sreg_we[SREG_IH] = accept & sel_in;
    end

    special_reg_bank #(
        .NUM_REGS (NUM_SREGS),
        .W        (WIDTH),
        .RST_VAL  ({WIDTH'(0), WIDTH'(0), WIDTH'(SP_INIT)})
    ) u_sregs (
        .clk   (clk),
        .rst   (rst),
        .we    (sreg_we),
        .wdata (bus.result),
        .q     (sreg_q)
    );

    // Strobes are recomputed every edge so a held (stalled) slot cannot repeat a pulse;
    // the address/data fields only move when their strobe fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            dst_err_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            reg_we_q  <= accept & sel_rx;
            pc_load_q <= accept & sel_pc;
            dst_err_q <= accept & illegal;
            if (accept & sel_rx) begin
                reg_waddr_q <= bus.rd_addr;
                reg_wdata_q <= bus.result;
            end
            if (accept & sel_pc)
                pc_target_q <= bus.result;
            if (accept & illegal)
                sticky_q <= 1'b1;
        end
    end

    assign bus.reg_we         = reg_we_q;
    assign bus.reg_waddr      = reg_waddr_q;
    assign bus.reg_wdata      = reg_wdata_q;
    assign bus.pc_load        = pc_load_q;
    assign bus.pc_target      = pc_target_q;
    assign bus.dst_err        = dst_err_q;
    assign bus.dst_err_sticky = sticky_q;
    assign bus.data_SP        = sreg_q[SREG_SP];
    assign bus.data_T         = sreg_q[SREG_T];
    assign bus.data_IN        = sreg_q[SREG_IH];

endmodule

// File: tb/tb_alu_dst_writeback.sv
// Bench for alu_dst_writeback: directed scenarios plus random traffic against a behavioural model.
module tb_alu_dst_writeback;
    import alu_dst_writeback_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_dst_writeback_if w ();

    alu_dst_writeback #(.SP_INIT(16'hBF00), .WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the visible outputs after each edge.
    logic        m_we, m_pc, m_err, m_sticky;
    logic [2:0]  m_waddr;
    logic [15:0] m_wdata, m_target, m_sp, m_t, m_ih;

    wire [86:0] obs = {w.reg_we, w.reg_waddr, w.reg_wdata, w.pc_load, w.pc_target,
                       w.data_SP, w.data_T, w.data_IN, w.dst_err, w.dst_err_sticky};
    wire [86:0] expv = {m_we, m_waddr, m_wdata, m_pc, m_target,
                        m_sp, m_t, m_ih, m_err, m_sticky};

    // Drive one cycle of inputs, let the edge happen, advance the model, settle.
    task automatic step(input logic v, input logic s, input logic f, input logic r,
                        input logic [7:0] code, input logic [2:0] ra, input logic [15:0] res);
        logic acc;
        w.wb_valid = v; w.stall = s; w.flush = f; rst = r;
        w.ALU_Dst = code; w.rd_addr = ra; w.result = res;
        @(posedge clk);
        acc = v && !s && !f;
        if (r) begin
            m_we = 0; m_pc = 0; m_err = 0; m_sticky = 0;
            m_waddr = 0; m_wdata = 0; m_target = 0;
            m_sp = 16'hBF00; m_t = 0; m_ih = 0;
        end else begin
            m_we = 0; m_pc = 0; m_err = 0;
            if (acc) begin
                if (code == 8'h05) begin m_we = 1; m_waddr = ra; m_wdata = res; end
                else if (code == 8'h13) begin m_pc = 1; m_target = res; end
                else if (code == 8'h09) m_sp = res;
                else if (code == 8'h0A) m_t = res;
                else if (code == 8'h08) m_ih = res;
                else if (code != 8'h10) begin m_err = 1; m_sticky = 1; end
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, CODE_NONE, 3'd0, 16'h0);
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1, CODE_NONE, 3'd0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            idle();
            total++;
            if (obs !== {1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 16'hBF00, 16'h0, 16'h0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset_idle%0d got=%h want SP=BF00 all else 0", i, obs);
            end
        end
    endtask

    task automatic test_special_regs();
        step(1, 0, 0, 0, CODE_SP, 3'd0, 16'h1234);
        total++;
        if (w.data_SP !== 16'h1234 || w.data_T !== 16'h0) begin
            bad++;
            $display("FAIL sp_write got SP=%h T=%h want 1234/0000", w.data_SP, w.data_T);
        end
        step(1, 0, 0, 0, CODE_T, 3'd0, 16'h0001);
        total++;
        if (w.data_SP !== 16'h1234 || w.data_T !== 16'h0001 || w.data_IN !== 16'h0) begin
            bad++;
            $display("FAIL t_write got SP=%h T=%h IN=%h want 1234/0001/0000",
                     w.data_SP, w.data_T, w.data_IN);
        end
        step(1, 0, 0, 0, CODE_IN, 3'd0, 16'h7E57);
        total++;
        if (w.data_IN !== 16'h7E57 || obs !== expv) begin
            bad++;
            $display("FAIL in_write got IN=%h obs=%h want IN=7e57 model=%h", w.data_IN, obs, expv);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 0, CODE_RX, 3'd3, 16'hABCD);
            total++;
            if (w.reg_we !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d got reg_we=%b want 0", i, w.reg_we);
            end
        end
        step(1, 0, 0, 0, CODE_RX, 3'd3, 16'hABCD);
        total++;
        if ({w.reg_we, w.reg_waddr, w.reg_wdata} !== {1'b1, 3'd3, 16'hABCD}) begin
            bad++;
            $display("FAIL rx_pulse got we=%b a=%0d d=%h want 1/3/abcd",
                     w.reg_we, w.reg_waddr, w.reg_wdata);
        end
        idle();
        total++;
        if ({w.reg_we, w.reg_waddr, w.reg_wdata} !== {1'b0, 3'd3, 16'hABCD}) begin
            bad++;
            $display("FAIL rx_drop got we=%b a=%0d d=%h want 0/3/abcd held",
                     w.reg_we, w.reg_waddr, w.reg_wdata);
        end
    endtask

    task automatic test_flush();
        step(1, 0, 1, 0, CODE_PC, 3'd0, 16'h0040);
        total++;
        if (w.pc_load !== 1'b0) begin
            bad++;
            $display("FAIL flush_pc got pc_load=%b want 0", w.pc_load);
        end
        step(1, 1, 1, 0, CODE_SP, 3'd0, 16'hDEAD);
        total++;
        if (w.data_SP !== 16'h1234) begin
            bad++;
            $display("FAIL flush_stall_sp got SP=%h want 1234", w.data_SP);
        end
        step(1, 0, 0, 0, CODE_PC, 3'd0, 16'h0040);
        total++;
        if ({w.pc_load, w.pc_target} !== {1'b1, 16'h0040}) begin
            bad++;
            $display("FAIL pc_pulse got load=%b tgt=%h want 1/0040", w.pc_load, w.pc_target);
        end
        idle();
        total++;
        if ({w.pc_load, w.pc_target} !== {1'b0, 16'h0040}) begin
            bad++;
            $display("FAIL pc_drop got load=%b tgt=%h want 0/0040", w.pc_load, w.pc_target);
        end
    endtask

    task automatic test_illegal();
        step(1, 0, 0, 0, 8'hFF, 3'd1, 16'h5555);
        total++;
        if ({w.dst_err, w.dst_err_sticky, w.reg_we, w.pc_load} !== 4'b1100 ||
            w.data_SP !== 16'h1234 || w.data_T !== 16'h0001 || w.data_IN !== 16'h7E57) begin
            bad++;
            $display("FAIL illegal got err=%b sticky=%b we=%b pc=%b SP=%h T=%h IN=%h",
                     w.dst_err, w.dst_err_sticky, w.reg_we, w.pc_load, w.data_SP, w.data_T, w.data_IN);
        end
        idle();
        total++;
        if ({w.dst_err, w.dst_err_sticky} !== 2'b01) begin
            bad++;
            $display("FAIL err_after got err=%b sticky=%b want 0/1", w.dst_err, w.dst_err_sticky);
        end
        step(0, 0, 0, 1, CODE_NONE, 3'd0, 16'h0);
        total++;
        if (w.dst_err_sticky !== 1'b0 || w.data_SP !== 16'hBF00) begin
            bad++;
            $display("FAIL sticky_clear got sticky=%b SP=%h want 0/bf00", w.dst_err_sticky, w.data_SP);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 0, CODE_SP, 3'd0, 16'h0002);
        total++;
        if (w.data_SP !== 16'h0002) begin
            bad++;
            $display("FAIL b2b_first got SP=%h want 0002", w.data_SP);
        end
        step(1, 0, 0, 0, CODE_SP, 3'd0, 16'h0003);
        total++;
        if (w.data_SP !== 16'h0003) begin
            bad++;
            $display("FAIL b2b_second got SP=%h want 0003", w.data_SP);
        end
        step(1, 0, 0, 1, CODE_SP, 3'd0, 16'h0004);
        total++;
        if (w.data_SP !== 16'hBF00) begin
            bad++;
            $display("FAIL b2b_reset got SP=%h want bf00", w.data_SP);
        end
        idle();
        total++;
        if (w.data_SP !== 16'hBF00) begin
            bad++;
            $display("FAIL b2b_after got SP=%h want bf00", w.data_SP);
        end
    endtask

    task automatic test_random();
        logic [7:0] codes [8];
        codes = '{CODE_NONE, CODE_RX, CODE_IN, CODE_SP, CODE_T, CODE_PC, 8'hFF, 8'h00};
        for (int i = 0; i < 400; i++) begin
            logic [7:0] c;
            c = codes[$urandom_range(7)];
            if (c == 8'h00) c = 8'($urandom);
            step(($urandom_range(3) != 0), ($urandom_range(4) == 0), ($urandom_range(6) == 0),
                 ($urandom_range(40) == 0), c, 3'($urandom), 16'($urandom));
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random%0d code=%h got=%h want=%h", i, c, obs, expv);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        w.wb_valid = 0; w.stall = 0; w.flush = 0;
        w.ALU_Dst = CODE_NONE; w.rd_addr = 0; w.result = 0;
        test_reset();
        test_special_regs();
        test_stall();
        test_flush();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
